// File: rtl/pl_pkg.sv
// Shared types and default widths for the fetch/decode pipeline register.
package pl_pkg;
  localparam int unsigned ADDRESS_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF    = 32;
  localparam int unsigned BITS_THREADS_DEF  = 3;

  typedef struct packed {
    logic [ADDRESS_WIDTH_DEF-1:0] pc;
    logic [ADDRESS_WIDTH_DEF-1:0] pc_plus4;
    logic [DATA_WIDTH_DEF-1:0]    instr;
    logic [BITS_THREADS_DEF-1:0]  tid;
  } fd_payload_t;

  localparam fd_payload_t FD_BUBBLE = '0;
endpackage

// File: rtl/pl_slot.sv
// One pipeline slot: valid bit plus payload, payload zeroed whenever invalidated.
module pl_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load,
  input  logic         kill,
  input  logic [W-1:0] payload_in,
  output logic         valid,
  output logic [W-1:0] payload
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= payload_in;
    end else if (kill) begin
      valid   <= 1'b0;
      payload <= '0;
    end
  end

endmodule

// File: rtl/pl_reg_fd_hs.sv
// Fetch/decode pipeline register with valid/ready handshake, per-thread flush and clear.
// Define PL_REG_SKID_EN for a second (skid) slot that registers in_ready.
module pl_reg_fd_hs
  import pl_pkg::*;
#(
  parameter  int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter  int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter  int unsigned BITS_THREADS  = BITS_THREADS_DEF,
  localparam int unsigned NUM_THREADS   = 1 << BITS_THREADS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic [DATA_WIDTH-1:0]    instr_f,
  input  logic [BITS_THREADS-1:0]  tid_f,
  input  logic                     clr,
  input  logic                     flush_en,
  input  logic [NUM_THREADS-1:0]   flush_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [BITS_THREADS-1:0]  tid_d
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0]    instr;
    logic [BITS_THREADS-1:0]  tid;
  } payload_t;

  localparam int unsigned PW = $bits(payload_t);

  payload_t in_p, m_p, m_din;
  logic     m_v, m_load, m_kill, m_stay;
  logic     kill_m, kill_in, in_surv;

  assign in_p = '{pc: pc_f, pc_plus4: pc_plus4_f, instr: instr_f, tid: tid_f};

  assign kill_m  = clr || (flush_en && flush_mask[m_p.tid]);
  assign kill_in = clr || (flush_en && flush_mask[tid_f]);
  assign in_surv = in_valid && in_ready && !kill_in;

  // M keeps its entry only if it is stalled and not killed; a delivered entry always leaves.
  assign m_stay = m_v && !out_ready && !kill_m;

`ifdef PL_REG_SKID_EN
  payload_t s_p;
  logic     s_v, s_load, s_kill, s_surv, s_keep;
  logic     kill_s;

  assign in_ready = rst_n && !s_v;

  assign kill_s = clr || (flush_en && flush_mask[s_p.tid]);
  assign s_surv = s_v && !kill_s;
  assign s_keep = m_stay && s_surv;

  // S compacts into a freed M; the incoming beat fills whichever slot is then free.
  assign m_load = !m_stay && (s_surv || in_surv);
  assign m_din  = s_surv ? s_p : in_p;
  assign m_kill = !m_stay && !(s_surv || in_surv);
  assign s_load = !s_keep && in_surv && (m_stay || s_surv);
  assign s_kill = !s_keep && !s_load;

  pl_slot #(.W(PW)) u_slot_s (
    .clk        (clk),
    .clear_n    (rst_n),
    .load       (s_load),
    .kill       (s_kill),
    .payload_in (in_p),
    .valid      (s_v),
    .payload    (s_p)
  );
`else
  assign in_ready = rst_n && (!m_v || out_ready);

  assign m_load = !m_stay && in_surv;
  assign m_din  = in_p;
  assign m_kill = !m_stay && !in_surv;
`endif

  pl_slot #(.W(PW)) u_slot_m (
    .clk        (clk),
    .clear_n    (rst_n),
    .load       (m_load),
    .kill       (m_kill),
    .payload_in (m_din),
    .valid      (m_v),
    .payload    (m_p)
  );

  assign out_valid  = m_v;
  assign pc_d       = m_p.pc;
  assign pc_plus4_d = m_p.pc_plus4;
  assign instr_d    = m_p.instr;
  assign tid_d      = m_p.tid;

endmodule

// File: tb/tb_pl_reg_fd_hs.sv
// Directed, table-driven bench for pl_reg_fd_hs; follows PL_REG_SKID_EN if defined.
module tb_pl_reg_fd_hs;

`ifdef PL_REG_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk;
  logic        rst_n, in_valid, in_ready, clr, flush_en, out_valid, out_ready;
  logic [31:0] pc_f, pc_plus4_f, instr_f, pc_d, pc_plus4_d, instr_d;
  logic [2:0]  tid_f, tid_d;
  logic [7:0]  flush_mask;

  int checks = 0;
  int errors = 0;

  pl_reg_fd_hs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc_f       (pc_f),
    .pc_plus4_f (pc_plus4_f),
    .instr_f    (instr_f),
    .tid_f      (tid_f),
    .clr        (clr),
    .flush_en   (flush_en),
    .flush_mask (flush_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .instr_d    (instr_d),
    .tid_d      (tid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, iv;
    logic [31:0] pc;
    logic [2:0]  tid;
    logic        clr, fe;
    logic [7:0]  mask;
    logic        ordy;
    logic        exp_ir, exp_ov;
    logic [31:0] exp_pc;
    logic [2:0]  exp_tid;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] pc,
                              input logic [2:0] tid, input logic c, input logic fe,
                              input logic [7:0] mask, input logic ordy, input logic eir,
                              input logic eov, input logic [31:0] epc, input logic [2:0] etid);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.pc = pc; v.tid = tid; v.clr = c; v.fe = fe;
    v.mask = mask; v.ordy = ordy; v.exp_ir = eir; v.exp_ov = eov;
    v.exp_pc = epc; v.exp_tid = etid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks the whole decode-side beat; an invalid beat must be all zero.
  task automatic chk_out(input string name, input logic ov, input logic [31:0] pc,
                         input logic [2:0] tid);
    chk({name, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({name, ".pc_d"}, 64'(pc_d), ov ? 64'(pc) : 64'd0);
    chk({name, ".pc_plus4_d"}, 64'(pc_plus4_d), ov ? 64'(pc + 32'd4) : 64'd0);
    chk({name, ".instr_d"}, 64'(instr_d), ov ? 64'(instr_of(pc)) : 64'd0);
    chk({name, ".tid_d"}, 64'(tid_d), ov ? 64'(tid) : 64'd0);
  endtask

  task automatic set_in(input logic r, input logic iv, input logic [31:0] pc,
                        input logic [2:0] tid, input logic c, input logic fe,
                        input logic [7:0] mask, input logic ordy);
    rst_n = r; in_valid = iv; pc_f = pc; pc_plus4_f = pc + 32'd4;
    instr_f = instr_of(pc); tid_f = tid; clr = c; flush_en = fe;
    flush_mask = mask; out_ready = ordy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);

    tbl[0]  = mk(0, 1, 32'h100, 0, 0, 0, 8'h00, 1, 0,    0, 32'h0,   0);
    tbl[1]  = mk(0, 1, 32'h100, 0, 0, 0, 8'h00, 1, 0,    0, 32'h0,   0);
    tbl[2]  = mk(1, 1, 32'h100, 0, 0, 0, 8'h00, 1, 1,    1, 32'h100, 0);
    tbl[3]  = mk(1, 1, 32'h104, 1, 0, 0, 8'h00, 1, 1,    1, 32'h104, 1);
    tbl[4]  = mk(1, 1, 32'h108, 2, 0, 0, 8'h00, 1, 1,    1, 32'h108, 2);
    tbl[5]  = mk(1, 0, 32'h0,   0, 0, 0, 8'h00, 1, 1,    0, 32'h0,   0);
    tbl[6]  = mk(1, 1, 32'h300, 2, 0, 1, 8'h04, 1, 1,    0, 32'h0,   0);
    tbl[7]  = mk(1, 0, 32'h0,   0, 0, 0, 8'h00, 1, 1,    0, 32'h0,   0);
    tbl[8]  = mk(1, 1, 32'h400, 4, 0, 0, 8'h00, 1, 1,    1, 32'h400, 4);
    tbl[9]  = mk(1, 1, 32'h404, 4, 0, 1, 8'h10, 1, 1,    0, 32'h0,   0);
    tbl[10] = mk(1, 1, 32'h500, 1, 0, 0, 8'h00, 1, 1,    1, 32'h500, 1);
    tbl[11] = mk(1, 0, 32'h0,   0, 0, 1, 8'h01, 0, SKID, 1, 32'h500, 1);
    tbl[12] = mk(1, 0, 32'h0,   0, 0, 1, 8'h02, 0, SKID, 0, 32'h0,   0);
    tbl[13] = mk(1, 1, 32'h600, 0, 0, 0, 8'h00, 0, 1,    1, 32'h600, 0);
    tbl[14] = mk(1, 1, 32'h604, 0, 1, 0, 8'h00, 0, SKID, 0, 32'h0,   0);
    tbl[15] = mk(1, 0, 32'h0,   0, 0, 0, 8'h00, 1, 1,    0, 32'h0,   0);

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].rst_n, tbl[i].iv, tbl[i].pc, tbl[i].tid, tbl[i].clr,
             tbl[i].fe, tbl[i].mask, tbl[i].ordy);
      chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].exp_ir));
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_ov, tbl[i].exp_pc, tbl[i].exp_tid);
    end

    // Back-pressure with pc 0x200 held in M
    set_in(1, 1, 32'h200, 0, 0, 0, 8'h00, 0);
    step();
    chk_out("bp_m", 1, 32'h200, 0);
    set_in(1, 1, 32'h204, 1, 0, 0, 8'h00, 0);
`ifdef PL_REG_SKID_EN
    chk("bp_skid_accept", 64'(in_ready), 64'd1);
    step();
    chk_out("bp_hold", 1, 32'h200, 0);
    set_in(1, 0, 32'h0, 0, 0, 0, 8'h00, 0);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    set_in(1, 0, 32'h0, 0, 0, 0, 8'h00, 1);
    step();
    chk_out("bp_drain_s", 1, 32'h204, 1);
    chk("bp_ready_after_drain", 64'(in_ready), 64'd1);
    step();
    chk_out("bp_empty", 0, 32'h0, 0);
`else
    chk("bp_no_skid_ready", 64'(in_ready), 64'd0);
    step();
    chk_out("bp_hold", 1, 32'h200, 0);
    set_in(1, 0, 32'h0, 0, 0, 0, 8'h00, 1);
    step();
    chk_out("bp_empty", 0, 32'h0, 0);
`endif

    // Selective flush of the older thread-3 entry while stalled
    set_in(1, 1, 32'h700, 3, 0, 0, 8'h00, 0);
    step();
`ifdef PL_REG_SKID_EN
    set_in(1, 1, 32'h704, 5, 0, 0, 8'h00, 0);
    step();
    chk_out("sf_before", 1, 32'h700, 3);
    set_in(1, 0, 32'h0, 0, 0, 1, 8'h08, 0);
    step();
    chk_out("sf_compact", 1, 32'h704, 5);
    set_in(1, 0, 32'h0, 0, 0, 0, 8'h00, 1);
    step();
    chk_out("sf_drained", 0, 32'h0, 0);
`else
    chk_out("sf_before", 1, 32'h700, 3);
    set_in(1, 0, 32'h0, 0, 0, 1, 8'h08, 0);
    step();
    chk_out("sf_killed", 0, 32'h0, 0);
`endif

    // Global clear while stalled with an incoming beat
    set_in(1, 1, 32'h800, 0, 0, 0, 8'h00, 0);
    step();
`ifdef PL_REG_SKID_EN
    set_in(1, 1, 32'h804, 1, 0, 0, 8'h00, 0);
    step();
`endif
    chk_out("clr_before", 1, 32'h800, 0);
    set_in(1, 1, 32'h808, 2, 1, 0, 8'h00, 0);
    chk("clr_full_ready", 64'(in_ready), 64'd0);
    step();
    chk_out("clr_after", 0, 32'h0, 0);
    set_in(1, 0, 32'h0, 0, 0, 0, 8'h00, 0);
    chk("clr_ready_after", 64'(in_ready), 64'd1);

    // Reset while full and stalled, then resume streaming
    set_in(1, 1, 32'hA00, 3, 0, 0, 8'h00, 0);
    step();
`ifdef PL_REG_SKID_EN
    set_in(1, 1, 32'hA04, 4, 0, 0, 8'h00, 0);
    step();
`endif
    chk_out("rst_before", 1, 32'hA00, 3);
    set_in(0, 1, 32'hA08, 5, 0, 0, 8'h00, 0);
    chk("rst_ready_low", 64'(in_ready), 64'd0);
    step();
    chk_out("rst_after", 0, 32'h0, 0);
    set_in(1, 1, 32'h900, 6, 0, 0, 8'h00, 1);
    chk("rst_resume_ready", 64'(in_ready), 64'd1);
    step();
    chk_out("rst_resume0", 1, 32'h900, 6);
    set_in(1, 1, 32'h904, 7, 0, 0, 8'h00, 1);
    step();
    chk_out("rst_resume1", 1, 32'h904, 7);
    set_in(1, 0, 32'h0, 0, 0, 0, 8'h00, 1);
    step();
    chk_out("rst_resume_end", 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_reg_fd_hs.md
Name: pl_reg_fd_hs

Overview:
- Parametrised successor to the fetch/decode pipeline register for the barrel core.
- Replaces the global `en`/`clr` pair with three mechanisms:
  - a valid/ready handshake;
  - per-thread selective flush, using a thread mask;
  - a global clear.
- Carries pc, pc+4, instruction and thread id from fetch to decode.
- Holds one or two entries, depending on the skid option. Invalid output slots present an all-zero payload, which is a NOP-equivalent bubble.

Parameters:
- ADDRESS_WIDTH, 32, width of pc and pc_plus4.
- DATA_WIDTH, 32, width of instr.
- BITS_THREADS, 3, width of tid.
- NUM_THREADS, 1<<BITS_THREADS, width of flush_mask. Derived; do not override.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  block accepts a beat this cycle.
- pc_f  in  ADDRESS_WIDTH  fetch pc.
- pc_plus4_f  in  ADDRESS_WIDTH  fetch pc+4.
- instr_f  in  DATA_WIDTH  fetched instruction.
- tid_f  in  BITS_THREADS  fetch thread id.
- clr  in  1  global flush; kills all entries and the incoming beat.
- flush_en  in  1  selective flush strobe.
- flush_mask  in  NUM_THREADS  bit t set means kill entries with tid==t.
- out_valid  out  1  decode-side beat valid.
- out_ready  in  1  decode accepts the beat.
- pc_d  out  ADDRESS_WIDTH  pc to decode.
- pc_plus4_d  out  ADDRESS_WIDTH  pc+4 to decode.
- instr_d  out  DATA_WIDTH  instruction to decode.
- tid_d  out  BITS_THREADS  thread id to decode.

Behaviour:
- Reset: while rst_n=0 at posedge, all slot valids=0 and all payloads=0.
  - Outputs after reset: out_valid=0, pc_d/pc_plus4_d/instr_d/tid_d=0.
  - in_ready is forced 0 combinationally while rst_n=0.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - Latency from input transfer to out_valid is 1 cycle when the block is empty.
- Storage:
  - Slot M (main) drives the outputs.
  - Slot S (skid) exists only with the skid option.
  - Order is preserved: M is always the older entry.
- Payload when invalid: outputs are the M payload; M payload is zeroed whenever M becomes invalid.
- Kill rule, evaluated per edge:
  - kill(x) = clr || (flush_en && flush_mask[x.tid]).
  - Applies to M, to S, and to the incoming beat.
  - A killed incoming beat is still consumed: the handshake completes and nothing is stored.
- Same-cycle output handshake and flush: an entry completing its output handshake in a cycle is delivered. Kill applies only to the entries that remain.
- Priority at each edge:
  1. rst_n.
  2. clr.
  3. Selective kill.
  4. Advance and compaction.
  5. Load.
- Compaction: if M is empty or leaving and S survives, S moves to M. An incoming surviving beat then goes to the freed slot, M if free, else S.
- Back-pressure: no beat is ever dropped except by kill. When out_ready=0 and M is valid, M holds its payload stable.
- Simultaneous in and out handshake with M occupied: M takes the next entry (S if valid, else the incoming beat) with no bubble.
- Throughput: a full-rate stream at 1 beat/cycle passes through with out_ready=1.

Optional Feature:
- Macro PL_REG_SKID_EN.
- Defined:
  - Two slots, M and S.
  - in_ready = rst_n && !S.valid, which is a registered signal with no combinational path from out_ready.
  - After out_ready drops, the block accepts one extra beat into S.
- Undefined:
  - Single slot M, with no S logic.
  - in_ready = rst_n && (!M.valid || out_ready), which is combinational from out_ready.
  - Kill and clr semantics are identical to the defined case.

Decomposition:
- Package pl_pkg:
  - ADDRESS_WIDTH/DATA_WIDTH/BITS_THREADS defaults.
  - Typedef fd_payload_t, a struct {pc, pc_plus4, instr, tid}.
  - Constant FD_BUBBLE, an all-zero payload.
- Sub-module pl_slot: one valid bit plus payload register.
  - Inputs: load, payload_in, kill, clear_n.
  - Zeroes its payload when invalidated.
  - Instantiated once, or twice under PL_REG_SKID_EN.

Test Plan:
- Reset then stream: rst_n low 2 cycles, then in_valid=1 with pc_f=0x100,0x104,0x108 and tids 0,1,2, out_ready=1.
  - Required: out_valid rises 1 cycle after the first beat; pc_d=0x100,0x104,0x108 on consecutive cycles; no bubbles.
- Back-pressure: out_ready=0 with pc 0x200 held in M.
  - Skid defined: a second beat 0x204 is accepted, then in_ready=0. Release out_ready → 0x200 then 0x204 in order, with in_ready=1 the cycle after S drains.
  - Skid undefined: in_ready=0 immediately.
- Selective flush: M holds tid=3, S holds tid=5, flush_en=1 with flush_mask=8'b0000_1000, out_ready=0.
  - Required: next cycle M holds the former S entry (tid=5); out_valid=1; the tid=3 entry never appears.
- Incoming-beat kill: in_valid=1 with tid_f=2 in the same cycle as flush_en with mask bit 2 set.
  - Required: the handshake completes (in_ready=1); the beat never reaches out_valid; outputs stay zero if the block was empty.
- clr during stall: M and S full, out_ready=0, clr=1 together with in_valid=1.
  - Required: next cycle out_valid=0, instr_d=0, in_ready=1.
- Reset mid-operation: rst_n=0 while full and stalled.
  - Required: in_ready=0 during reset; all outputs zero after the edge; normal streaming resumes on the first cycle with rst_n=1.
